flowmap_depth_labeller: RTL and testbench

//  Streaming depth-label engine for LUT-mapping experiments. Nodes of a

---
 rtl/flowmap_depth_labeller_if.sv | 32 +++
 rtl/flowmap_depth_labeller.sv | 140 ++++++++++++++
 tb/tb_flowmap_depth_labeller.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/flowmap_depth_labeller_if.sv
// Descriptor-in / label-out handshake bundle for the depth labeller.
// The master is the netlist streamer plus the label consumer; the slave is the engine.
interface flowmap_depth_labeller_if #(
  parameter int NODES = 64,
  parameter int FANIN = 2,
  parameter int LVL_W = 8
);
  localparam int IDW = $clog2(NODES);

  logic                 in_valid;
  logic                 in_ready;
  logic [IDW-1:0]       in_id;
  logic                 in_is_pi;
  logic [LVL_W-1:0]     in_level;
  logic [FANIN*IDW-1:0] in_fanin;
  logic [FANIN-1:0]     in_fanin_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [IDW-1:0]       out_id;
  logic [LVL_W-1:0]     out_level;
  logic                 out_err;

  modport master (
    output in_valid, in_id, in_is_pi, in_level, in_fanin, in_fanin_en, out_ready,
    input  in_ready, out_valid, out_id, out_level, out_err
  );

  modport slave (
    input  in_valid, in_id, in_is_pi, in_level, in_fanin, in_fanin_en, out_ready,
    output in_ready, out_valid, out_id, out_level, out_err
  );
endinterface

// File: rtl/flowmap_depth_labeller.sv
// Streaming depth labeller: PIs keep their preset level; other nodes get max(fanin levels)+1.
// Fanin slots are read serially, so there is one result per FANIN+2 cycles (PI: 2).
module flowmap_depth_labeller #(
  parameter int NODES = 64,
  parameter int FANIN = 2,
  parameter int LVL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  output logic                    busy,
  flowmap_depth_labeller_if.slave io
);
  localparam int IDW = $clog2(NODES);
  localparam int KW  = (FANIN > 1) ? $clog2(FANIN) : 1;
  localparam logic [LVL_W-1:0] LVL_MAX = '1;

  typedef enum logic [1:0] {IDLE, READ, EMIT} state_t;

  state_t               state_q, state_d;
  logic [NODES-1:0]     vld_q;
  logic [LVL_W-1:0]     lvl_mem [NODES];
  logic [IDW-1:0]       id_q;
  logic                 pi_q;
  logic [LVL_W-1:0]     pre_lvl_q;
  logic [FANIN*IDW-1:0] fanin_q;
  logic [FANIN-1:0]     en_q;
  logic [LVL_W-1:0]     acc_q;
  logic                 err_q;
  logic [KW-1:0]        k_q;
  logic                 first_q;

  logic                 accept;
  logic                 last_slot;
  logic                 rd_en;
  logic [IDW-1:0]       rd_id;
  logic [LVL_W-1:0]     emit_lvl;
  logic                 emit_err;
  logic                 tbl_wr;

  assign io.in_ready = (state_q == IDLE) && !clear && !rst;
  assign accept      = io.in_valid && io.in_ready;
  assign last_slot   = (k_q == KW'(FANIN - 1));
  assign rd_id       = fanin_q[int'(k_q)*IDW +: IDW];
  assign rd_en       = en_q[k_q];
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    io.out_valid = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = io.in_is_pi ? EMIT : READ;
      READ: if (last_slot) state_d = EMIT;
      EMIT: begin
        io.out_valid = 1'b1;
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A non-PI with no enabled slot is a constant and sits at level 0.
  always_comb begin
    emit_lvl = '0;
    emit_err = err_q;
    if (pi_q) begin
      emit_lvl = pre_lvl_q;
    end else if (en_q != '0) begin
      if (acc_q == LVL_MAX) begin
        emit_lvl = LVL_MAX;
        emit_err = 1'b1;
      end else begin
        emit_lvl = acc_q + 1'b1;
      end
    end
  end

  assign io.out_id    = io.out_valid ? id_q     : '0;
  assign io.out_level = io.out_valid ? emit_lvl : '0;
  assign io.out_err   = io.out_valid ? emit_err : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      id_q      <= '0;
      pi_q      <= 1'b0;
      pre_lvl_q <= '0;
      fanin_q   <= '0;
      en_q      <= '0;
      acc_q     <= '0;
      err_q     <= 1'b0;
      k_q       <= '0;
      first_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear) begin
            vld_q <= '0;
          end else if (accept) begin
            id_q      <= io.in_id;
            pi_q      <= io.in_is_pi;
            pre_lvl_q <= io.in_level;
            fanin_q   <= io.in_fanin;
            en_q      <= io.in_fanin_en;
            acc_q     <= '0;
            err_q     <= 1'b0;
            k_q       <= '0;
            first_q   <= 1'b1;
          end
        end
        READ: begin
          if (rd_en) begin
            if (!vld_q[rd_id])                err_q <= 1'b1;
            else if (lvl_mem[rd_id] > acc_q)  acc_q <= lvl_mem[rd_id];
          end
          if (!last_slot) k_q <= k_q + 1'b1;
        end
        EMIT: begin
          // Errored nodes lose any earlier label so consumers never see stale depth.
          if (first_q) begin
            first_q     <= 1'b0;
            vld_q[id_q] <= !emit_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign tbl_wr = !rst && (state_q == EMIT) && first_q && !emit_err;

  always_ff @(posedge clk) begin
    if (tbl_wr) lvl_mem[id_q] <= emit_lvl;
  end
endmodule

// File: tb/tb_flowmap_depth_labeller.sv
// Directed plus random checks of the depth labeller against an array-based label model.
module tb_flowmap_depth_labeller;
  localparam int NODES = 64;
  localparam int FANIN = 4;
  localparam int LVL_W = 8;
  localparam int IDW   = 6;
  localparam int LMAX  = (1 << LVL_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  bit   ref_vld [NODES];
  int   ref_lvl [NODES];

  always #5 clk = ~clk;

  flowmap_depth_labeller_if #(.NODES(NODES), .FANIN(FANIN), .LVL_W(LVL_W)) bus ();

  flowmap_depth_labeller #(.NODES(NODES), .FANIN(FANIN), .LVL_W(LVL_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .busy  (busy),
    .io    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [FANIN*IDW-1:0] mk(input int a, input int b, input int c, input int d);
    logic [IDW-1:0] ia, ib, ic, id;
    ia = IDW'(a); ib = IDW'(b); ic = IDW'(c); id = IDW'(d);
    return {id, ic, ib, ia};
  endfunction

  // Reference: read every enabled fanin label first, then label the node.
  task automatic model(input int id, input int pi, input int lvl, input logic [FANIN*IDW-1:0] fv,
                       input int en, output int el, output int ee);
    int acc, any, f;
    el = 0; ee = 0; acc = 0; any = 0;
    if (pi != 0) begin
      el = lvl;
    end else begin
      for (int k = 0; k < FANIN; k++) begin
        if (en[k]) begin
          any = 1;
          f = int'(fv[k*IDW +: IDW]);
          if (!ref_vld[f]) ee = 1;
          else if (ref_lvl[f] > acc) acc = ref_lvl[f];
        end
      end
      if (any != 0) begin
        if (acc + 1 > LMAX) begin el = LMAX; ee = 1; end
        else el = acc + 1;
      end
    end
    ref_vld[id] = (ee == 0);
    if (ee == 0) ref_lvl[id] = el;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NODES; i++) ref_vld[i] = 1'b0;
  endtask

  task automatic drive_in(input int id, input int pi, input int lvl, input logic [FANIN*IDW-1:0] fv, input int en);
    bus.in_valid    = 1'b1;
    bus.in_id       = IDW'(id);
    bus.in_is_pi    = pi[0];
    bus.in_level    = LVL_W'(lvl);
    bus.in_fanin    = fv;
    bus.in_fanin_en = FANIN'(en);
  endtask

  task automatic scramble_in();
    bus.in_valid    = 1'b0;
    bus.in_id       = IDW'($urandom);
    bus.in_is_pi    = 1'($urandom);
    bus.in_level    = LVL_W'($urandom);
    bus.in_fanin    = (FANIN*IDW)'($urandom);
    bus.in_fanin_en = FANIN'($urandom);
  endtask

  task automatic do_node(input string tag, input int id, input int pi, input int lvl,
                         input logic [FANIN*IDW-1:0] fv, input int en, input int stall,
                         input int clr_read, output int ol, output int oe);
    int el, ee, n;
    logic [IDW-1:0]   hold_id;
    logic [LVL_W-1:0] hold_lvl;
    logic             hold_err;
    model(id, pi, lvl, fv, en, el, ee);
    @(negedge clk);
    bus.out_ready = (stall == 0);
    drive_in(id, pi, lvl, fv, en);
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    scramble_in();
    if (clr_read != 0) clear = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    clear = 1'b0;
    chk({tag, ".latency"}, 32'(n), (pi != 0) ? 0 : FANIN);
    chk({tag, ".id"},    32'(bus.out_id),    32'(id));
    chk({tag, ".level"}, 32'(bus.out_level), 32'(el));
    chk({tag, ".err"},   32'(bus.out_err),   32'(ee));
    ol = int'(bus.out_level);
    oe = int'(bus.out_err);
    hold_id = bus.out_id; hold_lvl = bus.out_level; hold_err = bus.out_err;
    if (stall > 0) begin
      drive_in($urandom_range(0, NODES-1), 1, 7, '0, 0);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        chk({tag, ".hold_vld"}, 32'(bus.out_valid), 1);
        chk({tag, ".hold_lvl"}, 32'(bus.out_level), 32'(hold_lvl));
        chk({tag, ".hold_id"},  32'(bus.out_id),    32'(hold_id));
        chk({tag, ".hold_err"}, 32'(bus.out_err),   32'(hold_err));
        chk({tag, ".hold_rdy"}, 32'(bus.in_ready),  0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, ".next_rdy"}, 32'(bus.in_ready), 1);
    chk({tag, ".idle"},     32'(busy),         0);
  endtask

  initial begin
    int ol, oe, n, seen;
    int rid, rpi, rlvl, ren, rst_cnt;
    logic [FANIN*IDW-1:0] rfv;
    rst = 1'b1;
    clear = 1'b0;
    bus.out_ready = 1'b1;
    scramble_in();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready",  32'(bus.in_ready),  0);
    chk("rst.out_valid", 32'(bus.out_valid), 0);
    chk("rst.out_id",    32'(bus.out_id),    0);
    chk("rst.out_level", 32'(bus.out_level), 0);
    chk("rst.out_err",   32'(bus.out_err),   0);
    chk("rst.busy",      32'(busy),          0);
    rst = 1'b0;

    // Undefined fanin, then propagation of the error.
    do_node("undef9", 9, 0, 0, mk(5, 0, 0, 0), 4'b0001, 0, 0, ol, oe);
    chk("undef9.lvl_c", 32'(ol), 1); chk("undef9.err_c", 32'(oe), 1);
    do_node("use9", 20, 0, 0, mk(9, 0, 0, 0), 4'b0001, 0, 0, ol, oe);
    chk("use9.err_c", 32'(oe), 1);

    // Reference net.
    do_node("pi_a", 0, 1, 1, '0, 0, 0, 0, ol, oe);
    do_node("pi_b", 1, 1, 1, '0, 0, 0, 0, ol, oe);
    do_node("pi_c", 2, 1, 2, '0, 0, 0, 0, ol, oe);
    do_node("pi_d", 3, 1, 1, '0, 0, 0, 0, ol, oe);
    do_node("pi_e", 4, 1, 3, '0, 0, 0, 0, ol, oe);
    do_node("pi_f", 5, 1, 1, '0, 0, 0, 0, ol, oe);
    do_node("u",  10, 0, 0, mk(0, 1, 0, 0),   4'b0011, 0, 0, ol, oe); chk("u.lvl_c",  32'(ol), 2);
    do_node("w",  11, 0, 0, mk(2, 3, 0, 0),   4'b0011, 0, 0, ol, oe); chk("w.lvl_c",  32'(ol), 3);
    do_node("v",  12, 0, 0, mk(10, 11, 0, 0), 4'b0011, 0, 0, ol, oe); chk("v.lvl_c",  32'(ol), 4);
    do_node("n0", 13, 0, 0, mk(11, 4, 0, 0),  4'b0011, 0, 0, ol, oe); chk("n0.lvl_c", 32'(ol), 4);
    do_node("n1", 14, 0, 0, mk(13, 5, 0, 0),  4'b0011, 0, 0, ol, oe); chk("n1.lvl_c", 32'(ol), 5);
    do_node("n2", 15, 0, 0, mk(12, 14, 0, 0), 4'b0011, 0, 0, ol, oe);
    chk("n2.lvl_c", 32'(ol), 6); chk("n2.err_c", 32'(oe), 0);

    // Constant node, duplicate fanins, self-reference, redefinition.
    do_node("const", 16, 0, 0, mk(0, 1, 2, 3), 4'b0000, 0, 0, ol, oe); chk("const.lvl_c", 32'(ol), 0);
    do_node("dup",   17, 0, 0, mk(15, 15, 4, 15), 4'b1011, 0, 0, ol, oe); chk("dup.lvl_c", 32'(ol), 7);
    do_node("self",  17, 0, 0, mk(17, 0, 0, 0), 4'b0001, 0, 0, ol, oe); chk("self.lvl_c", 32'(ol), 8);
    do_node("redef", 10, 1, 9, '0, 0, 0, 0, ol, oe);

    // Saturation.
    do_node("sat_x", 30, 1, 255, '0, 0, 0, 0, ol, oe);
    do_node("sat_y", 31, 0, 0, mk(30, 0, 0, 0), 4'b0001, 0, 0, ol, oe);
    chk("sat_y.lvl_c", 32'(ol), 255); chk("sat_y.err_c", 32'(oe), 1);
    do_node("sat_z", 32, 0, 0, mk(31, 0, 0, 0), 4'b0001, 0, 0, ol, oe);
    chk("sat_z.err_c", 32'(oe), 1);

    // Backpressure on both a non-PI and a PI.
    do_node("bp_np", 33, 0, 0, mk(15, 4, 0, 0), 4'b0011, 5, 0, ol, oe);
    do_node("bp_pi", 34, 1, 6, '0, 0, 5, 0, ol, oe);

    // Clear in IDLE blocks the accept and wipes every label.
    @(negedge clk);
    clear = 1'b1;
    drive_in(35, 1, 3, '0, 0);
    #1;
    chk("clr.in_ready", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("clr.no_accept", 32'(busy), 0);
    clear = 1'b0;
    scramble_in();
    model_clear();
    do_node("after_clr", 40, 0, 0, mk(15, 0, 0, 0), 4'b0001, 0, 0, ol, oe);
    chk("after_clr.err_c", 32'(oe), 1);

    // Clear during READ is ignored.
    do_node("pi41", 41, 1, 3, '0, 0, 0, 0, ol, oe);
    do_node("clr_rd", 42, 0, 0, mk(41, 41, 41, 41), 4'b1111, 0, 1, ol, oe);
    do_node("post_clr_rd", 43, 0, 0, mk(42, 41, 0, 0), 4'b0011, 0, 0, ol, oe);
    chk("post_clr_rd.lvl_c", 32'(ol), 5); chk("post_clr_rd.err_c", 32'(oe), 0);

    // Reset in the middle of a four-fanin READ.
    @(negedge clk);
    drive_in(45, 0, 0, mk(41, 42, 43, 41), 4'b1111);
    @(posedge clk); #1;
    scramble_in();
    chk("rst_mid.busy", 32'(busy), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid.out_valid", 32'(bus.out_valid), 0);
    chk("rst_mid.busy_after", 32'(busy), 0);
    rst = 1'b0;
    model_clear();
    #1;
    chk("rst_mid.in_ready", 32'(bus.in_ready), 1);
    seen = 0;
    for (int c = 0; c < FANIN + 3; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    chk("rst_mid.no_emit", 32'(seen), 0);
    do_node("post_rst", 46, 0, 0, mk(41, 0, 0, 0), 4'b0001, 0, 0, ol, oe);
    chk("post_rst.err_c", 32'(oe), 1);

    // Random traffic over a small id window so fanins often hit defined labels.
    rst_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      rid  = $urandom_range(0, 15);
      rpi  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      rlvl = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 255) : $urandom_range(0, 12);
      rfv  = mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      ren  = $urandom_range(0, 15);
      n    = $urandom_range(0, 2);
      do_node("rand", rid, rpi, rlvl, rfv, ren, n, 0, ol, oe);
      rst_cnt++;
    end
    chk("rand.count", 32'(rst_cnt), 120);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
